ip_pkt_axis_rx_chk: RTL

// - Synthesizable AXI-Stream sink: receives 32-bit IPv4 packets and validates each one.
// - Sits at the receive end of an AXIS loop/datapath, e.g. after the axis_loop master port.
// - Parses the IPv4 header, checks version/IHL, header checksum, total length vs bytes received, and strobe framing.
// - Emits a one-cycle status pulse per packet and keeps packet/error counters.

---
 rtl/ip_pkt_axis_rx_chk_if.sv | 25 ++
 rtl/ip_pkt_axis_rx_chk.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_pkt_axis_rx_chk_if.sv
// AXI-Stream beat bundle feeding the IPv4 receive checker.
// The source drives data/strobe/last/valid and the sink drives ready.
interface ip_pkt_axis_rx_chk_if;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata,
    output tstrb,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/ip_pkt_axis_rx_chk.sv
// IPv4-over-AXIS sink: checks header, checksum, length and strobe framing.
// Define IP_RX_HDR_OUT_EN to also export source/destination address and protocol.
module ip_pkt_axis_rx_chk #(
  parameter int          CNT_W     = 32,
  parameter logic [15:0] MAX_BYTES = 16'd9000
) (
  input  logic             clk,
  input  logic             rst,
  ip_pkt_axis_rx_chk_if.slave s_axis,
  output logic             stat_valid,
  output logic             stat_ok,
  output logic [3:0]       stat_err,
  output logic [15:0]      stat_len,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
`ifdef IP_RX_HDR_OUT_EN
  output logic [31:0]      hdr_src_ip,
  output logic [31:0]      hdr_dst_ip,
  output logic [7:0]       hdr_proto,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_STAT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             rdy_q;
  logic [3:0]       widx_q, widx_d;
  logic [3:0]       ihl_q, ihl_d;
  logic             verr_q, verr_d;
  logic [15:0]      tlen_q, tlen_d;
  logic [19:0]      csum_q, csum_d;
  logic [15:0]      bcnt_q, bcnt_d;
  logic             ferr_q, ferr_d;
  logic             ok_q, ok_d;
  logic [3:0]       err_q, err_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

`ifdef IP_RX_HDR_OUT_EN
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [7:0]  prt_q, prt_d;
  logic [31:0] src_o_q, src_o_d;
  logic [31:0] dst_o_q, dst_o_d;
  logic [7:0]  prt_o_q, prt_o_d;
`endif

  logic        tready;
  logic        acc;
  logic        in_hdr;
  logic        w0;
  logic [3:0]  ihl_cur;
  logic [3:0]  hw;
  logic        last_hdr;
  logic [2:0]  lead;
  logic        strb_ok;
  logic [16:0] bsum;
  logic [15:0] bcnt_n;
  logic [19:0] csum_n;
  logic        verr_n;
  logic [15:0] tlen_n;
  logic        ferr_n;
  logic        hdr_inc;
  logic [19:0] f1;
  logic [19:0] f2;
  logic        ck_bad;
  logic        len_bad;
  logic [3:0]  err_n;

  assign tready        = rdy_q & (state_q != S_STAT);
  assign s_axis.tready = tready;
  assign acc           = s_axis.tvalid & tready;
  assign in_hdr        = (state_q == S_HDR);
  assign w0            = in_hdr & (widx_q == 4'd0);

  // Short IHL still consumes a minimum 20-byte header.
  assign ihl_cur  = w0 ? s_axis.tdata[27:24] : ihl_q;
  assign hw       = (ihl_cur < 4'd5) ? 4'd5 : ihl_cur;
  assign last_hdr = (widx_q == hw - 4'd1);

  always_comb begin
    lead = 3'd0;
    if (s_axis.tstrb[3]) begin
      lead = 3'd1;
      if (s_axis.tstrb[2]) begin
        lead = 3'd2;
        if (s_axis.tstrb[1]) begin
          lead = s_axis.tstrb[0] ? 3'd4 : 3'd3;
        end
      end
    end
  end

  assign strb_ok = (s_axis.tstrb == 4'b1111) |
                   (s_axis.tstrb == 4'b1110) |
                   (s_axis.tstrb == 4'b1100) |
                   (s_axis.tstrb == 4'b1000);

  assign bsum   = {1'b0, bcnt_q} +
                  (s_axis.tlast ? {14'd0, lead} : 17'd4);
  assign bcnt_n = bsum[16] ? 16'hFFFF : bsum[15:0];

  assign csum_n = in_hdr ?
                  csum_q + {4'd0, s_axis.tdata[31:16]}
                         + {4'd0, s_axis.tdata[15:0]} :
                  csum_q;

  assign verr_n = w0 ? ((s_axis.tdata[31:28] != 4'd4) |
                        (s_axis.tdata[27:24] < 4'd5)) :
                  verr_q;
  assign tlen_n = w0 ? s_axis.tdata[15:0] : tlen_q;

  assign hdr_inc = in_hdr & s_axis.tlast & ~last_hdr;
  assign ferr_n  = ferr_q | hdr_inc |
                   (s_axis.tlast ? ~strb_ok :
                                   (s_axis.tstrb != 4'b1111));

  assign f1      = {4'd0, csum_n[15:0]} + {16'd0, csum_n[19:16]};
  assign f2      = {4'd0, f1[15:0]} + {16'd0, f1[19:16]};
  assign ck_bad  = (f2[15:0] != 16'hFFFF);
  assign len_bad = (tlen_n != bcnt_n) | (bcnt_n > MAX_BYTES);
  assign err_n   = {ferr_n, ~hdr_inc & len_bad,
                    ~hdr_inc & ck_bad, verr_n};

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    ihl_d   = ihl_q;
    verr_d  = verr_q;
    tlen_d  = tlen_q;
    csum_d  = csum_q;
    bcnt_d  = bcnt_q;
    ferr_d  = ferr_q;
    ok_d    = ok_q;
    err_d   = err_q;
    len_d   = len_q;
    pcnt_d  = pcnt_q;
    ecnt_d  = ecnt_q;
`ifdef IP_RX_HDR_OUT_EN
    src_d   = src_q;
    dst_d   = dst_q;
    prt_d   = prt_q;
    src_o_d = src_o_q;
    dst_o_d = dst_o_q;
    prt_o_d = prt_o_q;
`endif
    unique case (state_q)
      S_HDR, S_PAY: begin
        if (acc) begin
          if (w0) begin
            ihl_d = s_axis.tdata[27:24];
          end
`ifdef IP_RX_HDR_OUT_EN
          if (in_hdr && widx_q == 4'd2) prt_d = s_axis.tdata[23:16];
          if (in_hdr && widx_q == 4'd3) src_d = s_axis.tdata;
          if (in_hdr && widx_q == 4'd4) dst_d = s_axis.tdata;
`endif
          if (s_axis.tlast) begin
            state_d = S_STAT;
            widx_d  = 4'd0;
            csum_d  = 20'd0;
            bcnt_d  = 16'd0;
            ferr_d  = 1'b0;
            err_d   = err_n;
            ok_d    = (err_n == 4'd0);
            len_d   = bcnt_n;
            pcnt_d  = pcnt_q + CNT_W'(1);
            if (err_n != 4'd0) begin
              ecnt_d = ecnt_q + CNT_W'(1);
            end
`ifdef IP_RX_HDR_OUT_EN
            src_o_d = src_d;
            dst_o_d = dst_d;
            prt_o_d = prt_d;
`endif
          end else begin
            verr_d = verr_n;
            tlen_d = tlen_n;
            csum_d = csum_n;
            bcnt_d = bcnt_n;
            ferr_d = ferr_n;
            if (in_hdr) begin
              widx_d = widx_q + 4'd1;
              if (last_hdr) begin
                state_d = S_PAY;
              end
            end
          end
        end
      end
      S_STAT: state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HDR;
      rdy_q   <= 1'b0;
      widx_q  <= 4'd0;
      ihl_q   <= 4'd0;
      verr_q  <= 1'b0;
      tlen_q  <= 16'd0;
      csum_q  <= 20'd0;
      bcnt_q  <= 16'd0;
      ferr_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 4'd0;
      len_q   <= 16'd0;
      pcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      widx_q  <= widx_d;
      ihl_q   <= ihl_d;
      verr_q  <= verr_d;
      tlen_q  <= tlen_d;
      csum_q  <= csum_d;
      bcnt_q  <= bcnt_d;
      ferr_q  <= ferr_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      len_q   <= len_d;
      pcnt_q  <= pcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

`ifdef IP_RX_HDR_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      prt_q   <= 8'd0;
      src_o_q <= 32'd0;
      dst_o_q <= 32'd0;
      prt_o_q <= 8'd0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      prt_q   <= prt_d;
      src_o_q <= src_o_d;
      dst_o_q <= dst_o_d;
      prt_o_q <= prt_o_d;
    end
  end

  assign hdr_src_ip = src_o_q;
  assign hdr_dst_ip = dst_o_q;
  assign hdr_proto  = prt_o_q;
`endif

  assign stat_valid = (state_q == S_STAT);
  assign stat_ok    = ok_q;
  assign stat_err   = err_q;
  assign stat_len   = len_q;
  assign pkt_cnt    = pcnt_q;
  assign err_cnt    = ecnt_q;
  assign busy       = (state_q == S_PAY) |
                      (in_hdr & (widx_q != 4'd0));

endmodule
